// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ packet requesters.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned UPDATE_HOLD    = 212,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_data_update,
  output logic [7:0]           tx_din,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HW = $clog2(UPDATE_HOLD + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT_DONE,
    ST_NEXT
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_update;
  logic [7:0]         r_tx_din;
  logic               r_busy;
  logic [2:0]         r_grant_id;
  logic               r_timeout;
  logic [2:0]         r_rr_ptr;
  logic               r_lock;
  logic [HW-1:0]      r_hold_cnt;
  logic [TW-1:0]      r_timer;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync3;

  logic [7:0]         w_bytes [NUM_REQ];
  logic               w_found;
  logic [2:0]         w_gnt;
  logic [2:0]         w_next_ptr;
  logic               w_done_evt;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = req_data[8*gi +: 8];
  end

  assign w_done_evt = r_sync2 & ~r_sync3;
  assign w_next_ptr = (r_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;

  assign req_ready      = r_req_ready;
  assign tx_data_update = r_update;
  assign tx_din         = r_tx_din;
  assign busy           = r_busy;
  assign grant_id       = r_grant_id;
  assign timeout_err    = r_timeout;

  // Round-robin search: first valid requester starting at r_rr_ptr.
  always_comb begin
    int unsigned v_idx;
    w_found = 1'b0;
    w_gnt   = 3'd0;
    v_idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[IW'(v_idx)]) begin
        w_found = 1'b1;
        w_gnt   = 3'(v_idx);
      end
    end
  end

  // tx_done synchroniser plus previous-value flop for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= tx_done;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Arbitration / transfer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= '0;
      r_update    <= 1'b0;
      r_tx_din    <= 8'h00;
      r_busy      <= 1'b0;
      r_grant_id  <= 3'd0;
      r_timeout   <= 1'b0;
      r_rr_ptr    <= 3'd0;
      r_lock      <= 1'b0;
      r_hold_cnt  <= '0;
      r_timer     <= '0;
    end else begin
      r_req_ready <= '0;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_tx_din    <= w_bytes[IW'(w_gnt)];
            r_req_ready <= NUM_REQ'(1) << w_gnt;
            r_grant_id  <= w_gnt;
            r_lock      <= ~req_last[IW'(w_gnt)];
            r_update    <= 1'b1;
            r_hold_cnt  <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HW'(UPDATE_HOLD - 1)) begin
            r_update <= 1'b0;
            r_timer  <= '0;
            r_state  <= ST_WAIT_DONE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (w_done_evt) begin
            if (r_lock) begin
              r_state <= ST_NEXT;
            end else begin
              r_rr_ptr <= w_next_ptr;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_lock    <= 1'b0;
            r_rr_ptr  <= w_next_ptr;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_NEXT: begin
          // Locked packet: only the current owner may continue.
          if (req_valid[IW'(r_grant_id)]) begin
            r_tx_din    <= w_bytes[IW'(r_grant_id)];
            r_req_ready <= NUM_REQ'(1) << r_grant_id;
            r_lock      <= ~req_last[IW'(r_grant_id)];
            r_update    <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= ST_HOLD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART transmitter.
module tb_uart_tx_arbiter;

  localparam int unsigned BIT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_data_update;
  logic [7:0]  tx_din;
  logic        tx_done;
  logic        busy;
  logic [2:0]  grant_id;
  logic        timeout_err;

  logic        serial;
  logic        tx_en;
  logic        model_active;
  logic [7:0]  sent [$];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] base;
    logic [2:0] exp_g;
  } vec_t;

  vec_t tbl [12];

  uart_tx_arbiter #(.NUM_REQ(4), .UPDATE_HOLD(212), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data_update(tx_data_update),
    .tx_din(tx_din), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: frame starts when update falls, done pulses after the stop bit.
  initial begin
    logic [9:0] frame;
    tx_done      = 1'b0;
    serial       = 1'b1;
    model_active = 1'b0;
    forever begin
      @(negedge tx_data_update);
      if (tx_en && rst_n) begin
        model_active = 1'b1;
        frame = {1'b1, tx_din, 1'b0};
        for (int i = 0; i < 10; i++) begin
          serial = frame[i];
          repeat (BIT) @(negedge clk);
        end
        sent.push_back(frame[8:1]);
        tx_done = 1'b1;
        repeat (BIT) @(negedge clk);
        tx_done = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_ready(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) bound_fail(name);
  endtask

  task automatic wait_update_low(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!tx_data_update) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) bound_fail(name);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"},  32'(req_ready),      32'h0);
    chk({name, "_update"}, 32'(tx_data_update), 32'h0);
    chk({name, "_din"},    32'(tx_din),         32'h0);
    chk({name, "_busy"},   32'(busy),           32'h0);
    chk({name, "_grant"},  32'(grant_id),       32'h0);
    chk({name, "_tmo"},    32'(timeout_err),    32'h0);
  endtask

  initial begin
    logic        ok;
    int          cnt;
    int          base_sz;
    logic [7:0]  last_b;
    logic [9:0]  exp_line;
    logic [7:0]  lock_bytes [4];

    tbl[0]  = '{4'b1111, 8'h10, 3'd0};
    tbl[1]  = '{4'b1111, 8'h10, 3'd1};
    tbl[2]  = '{4'b1111, 8'h10, 3'd2};
    tbl[3]  = '{4'b1111, 8'h10, 3'd3};
    tbl[4]  = '{4'b1111, 8'h10, 3'd0};
    tbl[5]  = '{4'b0101, 8'h50, 3'd2};
    tbl[6]  = '{4'b0001, 8'h60, 3'd0};
    tbl[7]  = '{4'b1000, 8'h70, 3'd3};
    tbl[8]  = '{4'b0010, 8'h80, 3'd1};
    tbl[9]  = '{4'b0010, 8'h80, 3'd1};
    tbl[10] = '{4'b1100, 8'h90, 3'd2};
    tbl[11] = '{4'b1100, 8'h90, 3'd3};

    tx_en     = 1'b1;
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_data  = 32'h0;
    req_last  = 4'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte A5 from req0: hold length, serial frame, busy fall timing.
    req_data  = 32'h0000_00A5;
    req_last  = 4'b0001;
    req_valid = 4'b0001;
    wait_ready("a5_ready", ok);
    chk("a5_ready_mask", 32'(req_ready), 32'h1);
    chk("a5_din", 32'(tx_din), 32'hA5);
    req_valid = 4'b0;
    cnt = 0;
    for (int i = 0; i < 400 && tx_data_update; i++) begin
      cnt++;
      tick();
    end
    chk("a5_update_cycles", 32'(cnt), 32'd212);
    exp_line = 10'b11_0100_1010;
    repeat (16) tick();
    for (int i = 0; i < 10; i++) begin
      chk("a5_serial_bit", 32'(serial), 32'(exp_line[i]));
      if (i < 9) repeat (BIT) tick();
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) bound_fail("a5_done");
    tick();
    chk("a5_busy_2_after_done", 32'(busy), 32'h1);
    tick();
    chk("a5_busy_3_after_done", 32'(busy), 32'h0);
    chk("a5_sent_count", 32'(sent.size()), 32'd1);

    // Packet lock: req1 sends 31,32,33 while req2 waits with 44.
    base_sz = sent.size();
    lock_bytes[0] = 8'h31; lock_bytes[1] = 8'h32; lock_bytes[2] = 8'h33; lock_bytes[3] = 8'h44;
    req_data  = 32'h0044_3100;
    req_last  = 4'b0100;
    req_valid = 4'b0110;
    for (int n = 0; n < 4; n++) begin
      wait_ready("lock_ready", ok);
      if (!ok) break;
      chk("lock_sent_before_accept", 32'(sent.size()), 32'(base_sz + n));
      chk("lock_din", 32'(tx_din), 32'(lock_bytes[n]));
      if (n < 3) begin
        chk("lock_ready_mask", 32'(req_ready), 32'h2);
        chk("lock_grant", 32'(grant_id), 32'd1);
        if (n < 2) begin
          req_data[15:8] = lock_bytes[n+1];
          req_last[1]    = (n == 1);
        end else begin
          req_valid[1] = 1'b0;
        end
      end else begin
        chk("lock_ready_mask_req2", 32'(req_ready), 32'h4);
        chk("lock_grant_req2", 32'(grant_id), 32'd2);
        req_valid[2] = 1'b0;
      end
    end
    req_valid = 4'b0;
    wait_idle("lock_idle");
    chk("lock_sent_total", 32'(sent.size()), 32'(base_sz + 4));
    for (int n = 0; n < 4 && base_sz + n < sent.size(); n++) begin
      last_b = sent[base_sz + n];
      chk("lock_order", 32'(last_b), 32'(lock_bytes[n]));
    end

    // Timeout: transmitter silent, req3 sends 7E.
    tx_en     = 1'b0;
    req_data  = 32'h7E00_0000;
    req_last  = 4'b1000;
    req_valid = 4'b1000;
    wait_ready("tmo_ready", ok);
    chk("tmo_ready_mask", 32'(req_ready), 32'h8);
    req_valid = 4'b0;
    wait_update_low("tmo_update_low");
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      cnt++;
      if (timeout_err) break;
    end
    chk("tmo_latency", 32'(cnt), 32'd4096);
    chk("tmo_busy", 32'(busy), 32'h0);
    tick();
    chk("tmo_pulse_width", 32'(timeout_err), 32'h0);
    tx_en = 1'b1;

    // Table-driven arbitration rounds (single-byte packets).
    for (int r = 0; r < 12; r++) begin
      base_sz = sent.size();
      for (int i = 0; i < 4; i++) req_data[8*i +: 8] = tbl[r].base + 8'(i);
      req_last  = 4'b1111;
      req_valid = tbl[r].mask;
      wait_ready("tbl_ready", ok);
      req_valid = 4'b0;
      chk("tbl_ready_mask", 32'(req_ready), 32'(4'b0001 << tbl[r].exp_g));
      chk("tbl_grant", 32'(grant_id), 32'(tbl[r].exp_g));
      chk("tbl_din", 32'(tx_din), 32'(tbl[r].base + 8'(tbl[r].exp_g)));
      chk("tbl_busy", 32'(busy), 32'h1);
      wait_idle("tbl_idle");
      chk("tbl_sent_count", 32'(sent.size()), 32'(base_sz + 1));
      if (sent.size() > 0) begin
        last_b = sent[sent.size()-1];
        chk("tbl_sent_byte", 32'(last_b), 32'(tbl[r].base + 8'(tbl[r].exp_g)));
      end
    end

    // Async reset during WAIT_DONE of the second byte of a 2-byte packet.
    req_data  = 32'h0000_0055;
    req_last  = 4'b0000;
    req_valid = 4'b0001;
    wait_ready("rst_ready1", ok);
    req_data[7:0] = 8'h66;
    req_last      = 4'b0001;
    wait_ready("rst_ready2", ok);
    chk("rst_second_din", 32'(tx_din), 32'h66);
    req_valid = 4'b0;
    wait_update_low("rst_update_low");
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (5) tick();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!model_active && !tx_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) bound_fail("rst_model_idle");
    rst_n = 1'b1;
    tick();
    req_data  = 32'h2322_2120;
    req_last  = 4'b1111;
    req_valid = 4'b1111;
    wait_ready("rst_after_ready", ok);
    req_valid = 4'b0;
    chk("rst_after_mask", 32'(req_ready), 32'h1);
    chk("rst_after_grant", 32'(grant_id), 32'd0);
    chk("rst_after_din", 32'(tx_din), 32'h20);
    wait_idle("rst_after_idle");
    if (sent.size() > 0) begin
      last_b = sent[sent.size()-1];
      chk("rst_after_sent", 32'(last_b), 32'h20);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
